// File: rtl/zap_exception_controller_pkg.sv
// Shared encodings for the ZAP exception controller: FSM states, exception
// priority selection and CPSR mask bit positions.
package zap_exception_controller_pkg;

   localparam int CPSR_I_BIT = 7;
   localparam int CPSR_F_BIT = 6;
   localparam int NUM_EXC    = 6;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPATCH = 2'd1,
      ST_FLUSH    = 2'd2
   } exc_state_t;

   // Enumeration order follows ARM entry priority, highest first.
   typedef enum logic [2:0] {
      EXC_NONE      = 3'd0,
      EXC_DATA_ABT  = 3'd1,
      EXC_FIQ       = 3'd2,
      EXC_IRQ       = 3'd3,
      EXC_INSTR_ABT = 3'd4,
      EXC_SWI       = 3'd5,
      EXC_UND       = 3'd6
   } exc_sel_t;

   function automatic logic cpsr_bit(input logic [31:0] cpsr, input int idx);
      return cpsr[idx];
   endfunction

   function automatic exc_sel_t exc_arbitrate(input logic data_abt, input logic fiq,
                                              input logic irq, input logic instr_abt,
                                              input logic swi, input logic und);
      exc_sel_t sel;
      if (data_abt)       sel = EXC_DATA_ABT;
      else if (fiq)       sel = EXC_FIQ;
      else if (irq)       sel = EXC_IRQ;
      else if (instr_abt) sel = EXC_INSTR_ABT;
      else if (swi)       sel = EXC_SWI;
      else if (und)       sel = EXC_UND;
      else                sel = EXC_NONE;
      return sel;
   endfunction

   // Strobe vector layout: {data_abt, fiq, irq, instr_abt, swi, und}.
   function automatic logic [NUM_EXC-1:0] exc_onehot(input exc_sel_t sel);
      logic [NUM_EXC-1:0] vec;
      case (sel)
         EXC_DATA_ABT:  vec = 6'b100000;
         EXC_FIQ:       vec = 6'b010000;
         EXC_IRQ:       vec = 6'b001000;
         EXC_INSTR_ABT: vec = 6'b000100;
         EXC_SWI:       vec = 6'b000010;
         EXC_UND:       vec = 6'b000001;
         default:       vec = 6'b000000;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/zap_exception_controller_chk.sv
// Invariants on the exception strobes seen by the register file.
module zap_exception_controller_chk (
   input logic       i_clk,
   input logic       i_reset,
   input logic [5:0] strobe,
   input logic       busy
);

   a_strobe_onehot0: assert property (@(posedge i_clk) disable iff (i_reset) $onehot0(strobe))
      else $error("exception strobes not one-hot: %b", strobe);

   a_strobe_busy: assert property (@(posedge i_clk) disable iff (i_reset) (strobe != 6'b0) |-> busy)
      else $error("exception strobe without busy");

endmodule

// File: rtl/zap_sync_ff.sv
// N-stage flip-flop synchroniser for an asynchronous level input.
module zap_sync_ff #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_r;

   // Shift the asynchronous level through the synchroniser chain.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], i_d};
      end
   end

   assign o_q = sync_r[STAGES-1];

endmodule

// File: rtl/zap_exception_controller.sv
// Arbitrates memory-stage exceptions and synchronised interrupts into a single
// registered one-hot entry strobe, followed by a flush blackout.
module zap_exception_controller
   import zap_exception_controller_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int FLUSH_CYCLES = 3,
   parameter int I_BIT        = CPSR_I_BIT,
   parameter int F_BIT        = CPSR_F_BIT
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_irq,
   input  logic        i_fiq,
   input  logic [31:0] i_cpsr,
   input  logic        i_mem_valid,
   input  logic        i_data_stall,
   input  logic        i_data_abt_req,
   input  logic        i_instr_abt_req,
   input  logic        i_swi_req,
   input  logic        i_und_req,
   input  logic        i_clear_from_writeback,
   output logic        o_data_abt,
   output logic        o_fiq,
   output logic        o_irq,
   output logic        o_instr_abt,
   output logic        o_swi,
   output logic        o_und,
   output logic        o_busy,
   output logic        o_irq_pending,
   output logic        o_fiq_pending
);

   // The dispatch cycle is the first blackout cycle, so FLUSH holds one fewer.
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   exc_state_t         state_r;
   logic [3:0]         flush_cnt_r;
   logic [NUM_EXC-1:0] strobe_r;
   logic               busy_r;

   logic               irq_sync_s;
   logic               fiq_sync_s;
   logic               irq_ok_s;
   logic               fiq_ok_s;
   logic               take_s;
   exc_sel_t           winner_s;
   logic [NUM_EXC-1:0] winner_vec_s;

   zap_sync_ff #(.STAGES(SYNC_STAGES)) u_irq_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_irq),
      .o_q     (irq_sync_s)
   );

   zap_sync_ff #(.STAGES(SYNC_STAGES)) u_fiq_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_fiq),
      .o_q     (fiq_sync_s)
   );

   // Mask interrupts, qualify eligibility and pick the highest-priority request.
   always_comb begin
      irq_ok_s     = irq_sync_s & ~cpsr_bit(i_cpsr, I_BIT);
      fiq_ok_s     = fiq_sync_s & ~cpsr_bit(i_cpsr, F_BIT);
      take_s       = i_mem_valid & ~i_data_stall & ~i_clear_from_writeback & (state_r == ST_IDLE);
      winner_s     = exc_arbitrate(i_data_abt_req, fiq_ok_s, irq_ok_s,
                                   i_instr_abt_req, i_swi_req, i_und_req);
      if (take_s) begin
         winner_vec_s = exc_onehot(winner_s);
      end else begin
         winner_vec_s = 6'b000000;
      end
   end

   // Entry sequencer: IDLE -> DISPATCH (strobe) -> FLUSH blackout -> IDLE.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r     <= ST_IDLE;
         flush_cnt_r <= 4'd0;
         strobe_r    <= 6'b000000;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               strobe_r <= winner_vec_s;
               if (winner_vec_s != 6'b000000) begin
                  state_r <= ST_DISPATCH;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_DISPATCH: begin
               strobe_r <= 6'b000000;
               if (FLUSH_CYCLES <= 1) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  flush_cnt_r <= FLUSH_LOAD;
                  state_r     <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               strobe_r <= 6'b000000;
               if (flush_cnt_r <= 4'd1) begin
                  flush_cnt_r <= 4'd0;
                  state_r     <= ST_IDLE;
                  busy_r      <= 1'b0;
               end else begin
                  flush_cnt_r <= flush_cnt_r - 4'd1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               flush_cnt_r <= 4'd0;
               strobe_r    <= 6'b000000;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign {o_data_abt, o_fiq, o_irq, o_instr_abt, o_swi, o_und} = strobe_r;
   assign o_busy        = busy_r;
   assign o_irq_pending = irq_ok_s;
   assign o_fiq_pending = fiq_ok_s;

   zap_exception_controller_chk u_chk (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .strobe  (strobe_r),
      .busy    (busy_r)
   );

endmodule

// File: tb/tb_zap_exception_controller.sv
// Directed per-cycle vector bench for zap_exception_controller.
module tb_zap_exception_controller;

   logic        clk = 1'b0;
   logic        reset, irq, fiq, mem_valid, data_stall;
   logic        data_abt_req, instr_abt_req, swi_req, und_req, clear_wb;
   logic [31:0] cpsr;
   logic        o_data_abt, o_fiq, o_irq, o_instr_abt, o_swi, o_und;
   logic        o_busy, o_irq_pending, o_fiq_pending;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   zap_exception_controller #(
      .SYNC_STAGES  (2),
      .FLUSH_CYCLES (3),
      .I_BIT        (7),
      .F_BIT        (6)
   ) dut (
      .i_clk                  (clk),
      .i_reset                (reset),
      .i_irq                  (irq),
      .i_fiq                  (fiq),
      .i_cpsr                 (cpsr),
      .i_mem_valid            (mem_valid),
      .i_data_stall           (data_stall),
      .i_data_abt_req         (data_abt_req),
      .i_instr_abt_req        (instr_abt_req),
      .i_swi_req              (swi_req),
      .i_und_req              (und_req),
      .i_clear_from_writeback (clear_wb),
      .o_data_abt             (o_data_abt),
      .o_fiq                  (o_fiq),
      .o_irq                  (o_irq),
      .o_instr_abt            (o_instr_abt),
      .o_swi                  (o_swi),
      .o_und                  (o_und),
      .o_busy                 (o_busy),
      .o_irq_pending          (o_irq_pending),
      .o_fiq_pending          (o_fiq_pending)
   );

   typedef struct {
      logic        rst, irq, fiq;
      logic [31:0] cpsr;
      logic        valid, stall, dabt, iabt, swi, und, clr;
      logic [5:0]  strb;
      logic        busy, ip, fp;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] C_U = 32'h0000_0013;
   localparam logic [31:0] C_I = 32'h0000_0093;
   localparam logic [5:0]  S_DA = 6'b100000, S_FQ = 6'b010000, S_IQ = 6'b001000;
   localparam logic [5:0]  S_IA = 6'b000100, S_SW = 6'b000010, S_UN = 6'b000001;

   function automatic vec_t mk(input logic rst, input logic i_q, input logic f_q,
                               input logic [31:0] c, input logic v, input logic st,
                               input logic da, input logic ia, input logic sw,
                               input logic un, input logic cl, input logic [5:0] s,
                               input logic b, input logic ip, input logic fp);
      vec_t r;
      r.rst = rst; r.irq = i_q; r.fiq = f_q; r.cpsr = c; r.valid = v; r.stall = st;
      r.dabt = da; r.iabt = ia; r.swi = sw; r.und = un; r.clr = cl;
      r.strb = s; r.busy = b; r.ip = ip; r.fp = fp;
      return r;
   endfunction

   function automatic logic [5:0] strobes();
      return {o_data_abt, o_fiq, o_irq, o_instr_abt, o_swi, o_und};
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst; irq = v.irq; fiq = v.fiq; cpsr = v.cpsr;
      mem_valid = v.valid; data_stall = v.stall; data_abt_req = v.dabt;
      instr_abt_req = v.iabt; swi_req = v.swi; und_req = v.und; clear_wb = v.clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      vec_t z;
      z = mk(0,0,0,0, 0,0,0,0,0,0,0, 6'b0,0,0,0);
      drive(z);

      // reset, idle
      vecs.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      for (int i = 0; i < 3; i++) vecs.push_back(z);
      // SWI held through the blackout: retaken only once back in IDLE
      vecs.push_back(mk(0,0,0,0, 1,0,0,0,1,0,0, S_SW,1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,0,0,1,0,0, 6'b0,1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,0,0,1,0,0, 6'b0,1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,0,0,1,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,0,0,1,0,0, S_SW,1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0, 6'b0,1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0, 6'b0,1,0,0));
      vecs.push_back(z);
      // stalled UND, then released
      vecs.push_back(mk(0,0,0,0, 1,1,0,0,0,1,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,1,0,0,0,1,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,0,0,0,1,0, S_UN,1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0, 6'b0,1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0, 6'b0,1,0,0));
      vecs.push_back(z);
      // prefetch abort flushed by writeback, then taken
      vecs.push_back(mk(0,0,0,0, 1,0,0,1,0,0,1, 6'b0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,0,1,0,0,0, S_IA,1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0, 6'b0,1,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0, 6'b0,1,0,0));
      vecs.push_back(z);
      // no valid instruction
      vecs.push_back(mk(0,0,0,0, 0,0,1,0,0,0,0, 6'b0,0,0,0));
      // FIQ synchronises, loses to data abort, taken after blackout
      vecs.push_back(mk(0,0,1,C_U, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,0,1,C_U, 0,0,0,0,0,0,0, 6'b0,0,0,1));
      vecs.push_back(mk(0,0,1,C_U, 1,0,1,0,1,0,0, S_DA,1,0,1));
      vecs.push_back(mk(0,0,1,C_U, 1,0,0,0,0,0,0, 6'b0,1,0,1));
      vecs.push_back(mk(0,0,1,C_U, 1,0,0,0,0,0,0, 6'b0,1,0,1));
      vecs.push_back(mk(0,0,1,C_U, 1,0,0,0,0,0,0, 6'b0,0,0,1));
      vecs.push_back(mk(0,0,1,C_U, 1,0,0,0,0,0,0, S_FQ,1,0,1));
      vecs.push_back(mk(0,0,0,C_U, 0,0,0,0,0,0,0, 6'b0,1,0,1));
      vecs.push_back(mk(0,0,0,C_U, 0,0,0,0,0,0,0, 6'b0,1,0,0));
      vecs.push_back(mk(0,0,0,C_U, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      // IRQ masked by I, unmasked, then I set again after entry
      vecs.push_back(mk(0,1,0,C_I, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,1,0,C_I, 1,0,0,0,0,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,1,0,C_I, 1,0,0,0,0,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,1,0,C_U, 0,0,0,0,0,0,0, 6'b0,0,1,0));
      vecs.push_back(mk(0,1,0,C_U, 1,0,0,0,0,0,0, S_IQ,1,1,0));
      vecs.push_back(mk(0,1,0,C_I, 1,0,0,0,0,0,0, 6'b0,1,0,0));
      vecs.push_back(mk(0,1,0,C_I, 1,0,0,0,0,0,0, 6'b0,1,0,0));
      vecs.push_back(mk(0,1,0,C_I, 1,0,0,0,0,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,1,0,C_I, 1,0,0,0,0,0,0, 6'b0,0,0,0));
      // IRQ entry, then reset in the following blackout cycle
      vecs.push_back(mk(0,1,0,C_U, 1,0,0,0,0,0,0, S_IQ,1,1,0));
      vecs.push_back(mk(1,1,0,C_U, 1,0,0,0,0,0,0, 6'b0,0,0,0));
      // short IRQ pulse that drops before any eligible cycle
      vecs.push_back(mk(0,0,0,C_U, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,1,0,C_U, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,0,0,C_U, 0,0,0,0,0,0,0, 6'b0,0,1,0));
      vecs.push_back(mk(0,0,0,C_U, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      vecs.push_back(mk(0,0,0,C_U, 1,0,0,0,0,0,0, 6'b0,0,0,0));

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         step();
         chk("strobes", i, 32'(strobes()), 32'(vecs[i].strb));
         chk("busy", i, 32'(o_busy), 32'(vecs[i].busy));
         chk("irq_pending", i, 32'(o_irq_pending), 32'(vecs[i].ip));
         chk("fiq_pending", i, 32'(o_fiq_pending), 32'(vecs[i].fp));
      end

      // async IRQ latency: rising pin to strobe is SYNC_STAGES+1 edges
      @(negedge clk);
      drive(mk(1,0,0,C_U, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      step();
      @(negedge clk);
      drive(mk(0,1,0,C_U, 1,0,0,0,0,0,0, 6'b0,0,0,0));
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         step();
         if (o_irq === 1'b1) lat = c;
      end
      chk("irq_latency", 0, 32'(lat), 32'd3);
      chk("irq_entry_strobes", 0, 32'(strobes()), 32'(S_IQ));
      step();
      chk("irq_one_cycle", 0, 32'(strobes()), 32'd0);
      chk("irq_busy_flush", 0, 32'(o_busy), 32'd1);

      // reset during the dispatch cycle itself
      @(negedge clk);
      drive(mk(1,0,0,C_U, 0,0,0,0,0,0,0, 6'b0,0,0,0));
      step();
      @(negedge clk);
      drive(mk(0,0,0,C_U, 1,0,0,0,1,0,0, 6'b0,0,0,0));
      step();
      chk("swi_dispatch", 1, 32'(strobes()), 32'(S_SW));
      @(negedge clk);
      drive(mk(1,0,0,C_U, 1,0,0,0,1,0,0, 6'b0,0,0,0));
      step();
      chk("reset_dispatch_strobes", 1, 32'(strobes()), 32'd0);
      chk("reset_dispatch_busy", 1, 32'(o_busy), 32'd0);
      @(negedge clk);
      drive(mk(0,0,0,C_U, 1,0,0,0,1,0,0, 6'b0,0,0,0));
      step();
      chk("swi_after_reset", 1, 32'(strobes()), 32'(S_SW));

      @(negedge clk);
      drive(z);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
